serial_adder: RTL and testbench

- Bit-serial adder that drives the single-bit full-adder cell.
- Loads two WIDTH-bit operands and a carry-in on a start pulse.
- Presents one bit pair per clock to the full-adder cell, keeps the running carry in a flop, and shifts sum bits into a result register.
- Sits between the project's operand registers/switch inputs and the display/result logic; trades WIDTH cycles of latency for a single adder cell.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_fa_bit.sv | 11 +
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding, default width,
// and the counter-width helper.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // 2'b11 is never entered; the FSM's default arm recovers it to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle between the operand source and serial_adder.
// SERIAL_ADDER_SUB_EN adds the sub request and the signed-overflow flag.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
    logic             ovf;

    modport master (output start, a, b, ci, sub, input busy, done, sum, co, ovf);
    modport slave  (input start, a, b, ci, sub, output busy, done, sum, co, ovf);
`else
    modport master (output start, a, b, ci, input busy, done, sum, co);
    modport slave  (input start, a, b, ci, output busy, done, sum, co);
`endif
endinterface

// File: rtl/serial_fa_bit.sv
// Single-bit full-adder cell shared by every bit position of the serial adder.
module serial_fa_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, WIDTH SHIFT cycles, one DONE cycle.
// SERIAL_ADDER_SUB_EN enables a - b via the sub input and reports ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    serial_adder_if.slave bus
);
    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_q;
    logic [CNT_W-1:0] cnt;
    logic             carry, co_q, done_q;
    logic             load, shift_en, finish;
    logic             fa_s, fa_cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic             carry_prev, ovf_q;
`endif

    serial_fa_bit u_fa (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register reading the
    // pre-edge value of its neighbours, which the shift chain relies on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            co_q   <= 1'b0;
            done_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            carry_prev <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            done_q <= finish;
            if (load) begin
                a_sr   <= bus.a;
                sum_sr <= '0;
                cnt    <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                // Two's-complement subtract: invert b and inject a carry of one.
                b_sr  <= bus.sub ? ~bus.b : bus.b;
                carry <= bus.sub | bus.ci;
`else
                b_sr  <= bus.b;
                carry <= bus.ci;
`endif
            end else if (shift_en) begin
                sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
                carry  <= fa_cout;
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                cnt    <= cnt + 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
                carry_prev <= carry;
`endif
            end
            if (finish) begin
                sum_q <= sum_sr;
                co_q  <= carry;
`ifdef SERIAL_ADDER_SUB_EN
                // carry_prev is the carry into the MSB, carry the carry out of it.
                ovf_q <= carry ^ carry_prev;
`endif
            end
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.co   = co_q;
`ifdef SERIAL_ADDER_SUB_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8; subtract vectors run only when
// SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // One start pulse, then watch busy/done; poke_idx>0 re-pulses start mid-SHIFT.
    task automatic run_op(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                          input logic ci_v, input logic sub_v, input logic [7:0] exp_sum,
                          input logic exp_co, input logic exp_ovf, input int poke_idx);
        int busy_cnt;
        int done_idx;
        int extra;
        logic [7:0] prev_sum;
        busy_cnt = 0;
        done_idx = 0;
        extra    = 0;
        @(negedge clk);
        prev_sum  = bus.sum;
        bus.start = 1'b1;
        bus.a     = a_v;
        bus.b     = b_v;
        bus.ci    = ci_v;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = sub_v;
`else
        if (sub_v) $display("note: %s sub ignored in add-only build", tag);
`endif
        for (int i = 1; i <= WIDTH + 6 && done_idx == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.start = 1'b0;
                bus.a     = 8'h5A;
                bus.b     = 8'hC3;
            end
            if (poke_idx > 0 && i == poke_idx) begin
                bus.start = 1'b1;
                bus.a     = 8'hAA;
            end
            if (poke_idx > 0 && i == poke_idx + 1) bus.start = 1'b0;
            if (i == WIDTH) check({tag, "_hold"}, 32'(bus.sum), 32'(prev_sum));
            if (bus.busy) busy_cnt++;
            if (bus.done) done_idx = i;
        end
        check({tag, "_busy_cycles"}, busy_cnt, WIDTH);
        check({tag, "_done_cycle"}, done_idx, WIDTH + 2);
        check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, "_co"}, 32'(bus.co), 32'(exp_co));
`ifdef SERIAL_ADDER_SUB_EN
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`else
        if (exp_ovf) $display("note: %s ovf not present in add-only build", tag);
`endif
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        check({tag, "_extra_done"}, extra, 0);
    endtask

    initial begin
        int done_cnt;
        int last_idx;
        int extra;
        n_vec     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.ci    = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_sum", 32'(bus.sum), 0);
        check("rst_co", 32'(bus.co), 0);
        reset = 1'b0;

        run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
        run_op("add_a5_5a_c", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op("ignore_start", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 3);

        // Reset during the fourth SHIFT cycle: outputs clear at once, no done.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h80;
        bus.b     = 8'h80;
        bus.ci    = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_sum", 32'(bus.sum), 0);
        check("abort_co", 32'(bus.co), 0);
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        check("abort_no_done", extra, 0);
        run_op("after_reset", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 0);

        // start held high: one result every WIDTH+2 cycles, sum steady between.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        bus.ci    = 1'b0;
        done_cnt  = 0;
        last_idx  = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                check("cont_spacing", i - last_idx, WIDTH + 2);
                check("cont_sum", 32'(bus.sum), 32'h02);
                last_idx = i;
            end else if (done_cnt > 0) begin
                check("cont_stable", 32'(bus.sum), 32'h02);
            end
        end
        check("cont_count", done_cnt, 3);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
